// File: rtl/operand_fetch_stage.sv
// Operand-fetch (issue) stage between decode and execute.
// Drives both RAM read ports from the decoded source fields. The RAM's
// registered read data arrives one cycle later and is presented to execute
// under a valid/ready handshake. A per-register scoreboard of outstanding
// writebacks stalls decode on read-after-write and write-after-write hazards.
module operand_fetch_stage #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int MEM_SIZE     = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    Clock,
    input  logic                    Reset,
    // decode side
    input  logic                    iValid,
    input  logic [OPCODE_WIDTH-1:0] iOpcode,
    input  logic [ADDR_WIDTH-1:0]   iSrc0,
    input  logic [ADDR_WIDTH-1:0]   iSrc1,
    input  logic [ADDR_WIDTH-1:0]   iDst,
    input  logic                    iWritesDst,
    output logic                    oReady,
    // register RAM read ports
    output logic [ADDR_WIDTH-1:0]   oReadAddress0,
    output logic [ADDR_WIDTH-1:0]   oReadAddress1,
    input  logic [DATA_WIDTH-1:0]   iRamData0,
    input  logic [DATA_WIDTH-1:0]   iRamData1,
    // writeback snoop
    input  logic                    iWbEnable,
    input  logic [ADDR_WIDTH-1:0]   iWbAddress,
    // execute side
    output logic                    oValid,
    input  logic                    iExecReady,
    output logic [OPCODE_WIDTH-1:0] oOpcode,
    output logic [ADDR_WIDTH-1:0]   oDst,
    output logic                    oWritesDst,
    output logic [DATA_WIDTH-1:0]   oOperand0,
    output logic [DATA_WIDTH-1:0]   oOperand1,
    // scoreboard visibility
    output logic [MEM_SIZE-1:0]     oPending
);

    // IDLE : nothing presented to execute
    // FRESH: operands come straight from the RAM's registered outputs
    // HELD : execute stalled us; operands replayed from the hold registers,
    //        because the RAM outputs follow whatever decode now presents
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRESH = 2'd1,
        HELD  = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [MEM_SIZE-1:0]     pending_reg;
    logic [MEM_SIZE-1:0]     pending_next;

    logic [OPCODE_WIDTH-1:0] opcode_reg;
    logic [ADDR_WIDTH-1:0]   dst_reg;
    logic                    writes_dst_reg;
    logic [DATA_WIDTH-1:0]   hold0_reg;
    logic [DATA_WIDTH-1:0]   hold1_reg;

    // one-hot decodes of each address against every tracked register
    logic [MEM_SIZE-1:0]     src0_hit;
    logic [MEM_SIZE-1:0]     src1_hit;
    logic [MEM_SIZE-1:0]     dst_hit;
    logic [MEM_SIZE-1:0]     wb_hit;

    logic [MEM_SIZE-1:0]     wb_clear;
    logic [MEM_SIZE-1:0]     live_pending;
    logic [MEM_SIZE-1:0]     dst_set;

    logic                    hazard_src0;
    logic                    hazard_src1;
    logic                    hazard_dst;
    logic                    hazard;
    logic                    out_valid;
    logic                    ready;
    logic                    issue;

    // Addresses at or beyond MEM_SIZE match no decode bit, so they can never
    // hazard and are never marked.
    generate
        for (genvar gi = 0; gi < MEM_SIZE; gi++) begin : g_decode
            assign src0_hit[gi] = (iSrc0      == ADDR_WIDTH'(gi));
            assign src1_hit[gi] = (iSrc1      == ADDR_WIDTH'(gi));
            assign dst_hit[gi]  = (iDst       == ADDR_WIDTH'(gi));
            assign wb_hit[gi]   = (iWbAddress == ADDR_WIDTH'(gi));
        end
    endgenerate

    // A writeback landing this cycle resolves its hazard now: the RAM forwards
    // same-cycle write data to a read of the same address.
    assign wb_clear     = iWbEnable ? wb_hit : '0;
    assign live_pending = pending_reg & ~wb_clear;

    assign hazard_src0 = |(live_pending & src0_hit);
    assign hazard_src1 = |(live_pending & src1_hit);
    assign hazard_dst  = iWritesDst & (|(live_pending & dst_hit));
    assign hazard      = hazard_src0 | hazard_src1 | hazard_dst;

    // Ready deliberately ignores iValid so decode can look before it commits.
    assign ready  = !hazard && (!out_valid || iExecReady);
    assign issue  = iValid && ready;
    assign oReady = ready;

    // Set beats clear: an issuing writer supersedes a retiring one.
    assign dst_set      = (issue && iWritesDst) ? dst_hit : '0;
    assign pending_next = live_pending | dst_set;

    assign oReadAddress0 = iSrc0;
    assign oReadAddress1 = iSrc1;
    assign oPending      = pending_reg;
    assign oOpcode       = opcode_reg;
    assign oDst          = dst_reg;
    assign oWritesDst    = writes_dst_reg;

    // State register
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic for the presentation FSM
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (issue) begin
                    state_next = FRESH;
                end
            end
            FRESH, HELD: begin
                if (!iExecReady) begin
                    state_next = HELD;
                end else if (issue) begin
                    state_next = FRESH;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: valid flag and operand source selection
    always_comb begin
        out_valid = 1'b0;
        oOperand0 = iRamData0;
        oOperand1 = iRamData1;
        case (state_reg)
            FRESH: begin
                out_valid = 1'b1;
            end
            HELD: begin
                out_valid = 1'b1;
                oOperand0 = hold0_reg;
                oOperand1 = hold1_reg;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign oValid = out_valid;

    // Scoreboard of registers with an outstanding writeback
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Instruction payload captured on issue, stable while execute stalls
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            opcode_reg     <= '0;
            dst_reg        <= '0;
            writes_dst_reg <= 1'b0;
        end else if (issue) begin
            opcode_reg     <= iOpcode;
            dst_reg        <= iDst;
            writes_dst_reg <= iWritesDst;
        end
    end

    // Snapshot RAM data on the first stalled cycle so operands survive the stall
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hold0_reg <= '0;
            hold1_reg <= '0;
        end else if (state_reg == FRESH && !iExecReady) begin
            hold0_reg <= iRamData0;
            hold1_reg <= iRamData1;
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Bench for operand_fetch_stage: models the external dual-read register RAM
// (registered read, write-through forwarding) and keeps a scoreboard of
// expected execute-side transactions plus a model of the pending bits.
module tb_operand_fetch_stage;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int MS = 8;
    localparam int OW = 4;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iValid;
    logic [OW-1:0] iOpcode;
    logic [AW-1:0] iSrc0, iSrc1, iDst;
    logic          iWritesDst;
    logic          oReady;
    logic [AW-1:0] oReadAddress0, oReadAddress1;
    logic [DW-1:0] iRamData0, iRamData1;
    logic          iWbEnable;
    logic [AW-1:0] iWbAddress;
    logic [DW-1:0] wb_data;
    logic          oValid;
    logic          iExecReady;
    logic [OW-1:0] oOpcode;
    logic [AW-1:0] oDst;
    logic          oWritesDst;
    logic [DW-1:0] oOperand0, oOperand1;
    logic [MS-1:0] oPending;

    operand_fetch_stage #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_SIZE(MS), .OPCODE_WIDTH(OW)
    ) dut (
        .Clock(Clock), .Reset(Reset),
        .iValid(iValid), .iOpcode(iOpcode), .iSrc0(iSrc0), .iSrc1(iSrc1),
        .iDst(iDst), .iWritesDst(iWritesDst), .oReady(oReady),
        .oReadAddress0(oReadAddress0), .oReadAddress1(oReadAddress1),
        .iRamData0(iRamData0), .iRamData1(iRamData1),
        .iWbEnable(iWbEnable), .iWbAddress(iWbAddress),
        .oValid(oValid), .iExecReady(iExecReady),
        .oOpcode(oOpcode), .oDst(oDst), .oWritesDst(oWritesDst),
        .oOperand0(oOperand0), .oOperand1(oOperand1), .oPending(oPending)
    );

    always #5 Clock = ~Clock;

    // External register RAM: registered read, same-cycle write forwarded
    logic [DW-1:0] mem [0:255];
    always @(posedge Clock) begin
        if (iWbEnable) mem[iWbAddress] <= wb_data;
        iRamData0 <= (iWbEnable && iWbAddress == oReadAddress0) ? wb_data : mem[oReadAddress0];
        iRamData1 <= (iWbEnable && iWbAddress == oReadAddress1) ? wb_data : mem[oReadAddress1];
    end

    typedef struct {
        logic [OW-1:0] op;
        logic [AW-1:0] dst;
        logic          wr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          sb[$];
    logic [MS-1:0] exp_pend;
    int            checks = 0;
    int            passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic pend_of(input logic [AW-1:0] a, input logic we, input logic [AW-1:0] wa);
        if (a >= AW'(MS)) return 1'b0;
        return exp_pend[a[2:0]] && !(we && wa == a);
    endfunction

    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a, input logic we,
                                              input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        return (we && wa == a) ? wd : mem[a];
    endfunction

    // One clock cycle: drive inputs, check mid-cycle, advance the model at the edge
    task automatic step(input logic v, input logic [OW-1:0] op, input logic [AW-1:0] s0,
                        input logic [AW-1:0] s1, input logic [AW-1:0] d, input logic wd,
                        input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wdat,
                        input logic er);
        logic hz, exp_ready, iss;
        exp_t e;
        iValid = v; iOpcode = op; iSrc0 = s0; iSrc1 = s1; iDst = d; iWritesDst = wd;
        iWbEnable = we; iWbAddress = wa; wb_data = wdat; iExecReady = er;
        @(negedge Clock);
        hz = pend_of(s0, we, wa) | pend_of(s1, we, wa) | (wd & pend_of(d, we, wa));
        exp_ready = !hz && (sb.size() == 0 || er);
        iss = v && exp_ready;
        check("ready", {31'd0, oReady}, {31'd0, exp_ready});
        check("valid", {31'd0, oValid}, {31'd0, sb.size() != 0});
        check("pending", {24'd0, oPending}, {24'd0, exp_pend});
        if (sb.size() != 0) begin
            check("opcode", {28'd0, oOpcode}, {28'd0, sb[0].op});
            check("dst", {24'd0, oDst}, {24'd0, sb[0].dst});
            check("writes", {31'd0, oWritesDst}, {31'd0, sb[0].wr});
            check("operand0", {16'd0, oOperand0}, {16'd0, sb[0].a});
            check("operand1", {16'd0, oOperand1}, {16'd0, sb[0].b});
        end
        e.op = op; e.dst = d; e.wr = wd;
        e.a = ram_val(s0, we, wa, wdat);
        e.b = ram_val(s1, we, wa, wdat);
        @(posedge Clock);
        if (sb.size() != 0 && er) begin
            $display("retire op=%0h dst=%0d a=%h b=%h", sb[0].op, sb[0].dst, sb[0].a, sb[0].b);
            void'(sb.pop_front());
        end
        if (iss) begin
            sb.push_back(e);
            $display("issue  op=%0h src=%0d,%0d dst=%0d w=%0b", op, s0, s1, d, wd);
        end
        if (we && wa < AW'(MS)) exp_pend[wa[2:0]] = 1'b0;
        if (iss && wd && d < AW'(MS)) exp_pend[d[2:0]] = 1'b1;
        #1;
    endtask

    task automatic idle(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wdat);
        step(1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 1'b0, we, wa, wdat, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        exp_pend = '0;
        Reset = 1'b1;
        iValid = 0; iOpcode = 0; iSrc0 = 0; iSrc1 = 0; iDst = 0; iWritesDst = 0;
        iWbEnable = 0; iWbAddress = 0; wb_data = 0; iExecReady = 1;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check("rst_valid", {31'd0, oValid}, 32'd0);
        check("rst_pending", {24'd0, oPending}, 32'd0);
        check("rst_opcode", {28'd0, oOpcode}, 32'd0);
        Reset = 1'b0;
        @(posedge Clock); #1;

        // 1: basic issue
        idle(1'b1, 8'd1, 16'h1111);
        idle(1'b1, 8'd2, 16'h2222);
        step(1'b1, 4'h1, 8'd1, 8'd2, 8'd3, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        idle(1'b0, 8'd0, 16'h0);

        // 2: RAW stall on r3 resolved by same-cycle writeback (reader also writes r3)
        step(1'b1, 4'h2, 8'd3, 8'd0, 8'd3, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        step(1'b1, 4'h2, 8'd3, 8'd0, 8'd3, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        step(1'b1, 4'h2, 8'd3, 8'd0, 8'd3, 1'b1, 1'b1, 8'd3, 16'hBEEF, 1'b1);
        idle(1'b0, 8'd0, 16'h0);
        idle(1'b1, 8'd3, 16'hCAFE);

        // 3: execute stall while the source register is rewritten
        idle(1'b1, 8'd4, 16'h4444);
        step(1'b1, 4'h3, 8'd4, 8'd1, 8'd9, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        for (int k = 0; k < 3; k++)
            step(1'b1, 4'h4, 8'd4, 8'd4, 8'd9, 1'b0, 1'b1, 8'd4, 16'h5000 + 16'(k), 1'b0);
        step(1'b1, 4'h4, 8'd4, 8'd4, 8'd9, 1'b0, 1'b0, 8'd0, 16'h0, 1'b1);
        idle(1'b0, 8'd0, 16'h0);

        // 4: back-to-back independent issues, including out-of-range destinations
        for (int k = 8; k < 16; k++) idle(1'b1, 8'(k), 16'(k * 16'h0101));
        for (int k = 0; k < 8; k++)
            step(1'b1, 4'(k), 8'($urandom_range(8, 15)), 8'($urandom_range(8, 15)),
                 8'($urandom_range(16, 40)), 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        idle(1'b0, 8'd0, 16'h0);

        // 5: WAW on r5 resolved by same-cycle clear; set must win
        step(1'b1, 4'h5, 8'd1, 8'd2, 8'd5, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        step(1'b1, 4'h6, 8'd1, 8'd2, 8'd5, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        step(1'b1, 4'h6, 8'd1, 8'd2, 8'd5, 1'b1, 1'b1, 8'd5, 16'h5555, 1'b1);
        idle(1'b0, 8'd0, 16'h0);

        // 6: asynchronous reset while HELD
        step(1'b1, 4'h7, 8'd1, 8'd2, 8'd6, 1'b1, 1'b0, 8'd0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        step(1'b0, 4'h0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 16'h0, 1'b0);
        #2 Reset = 1'b1;
        #1;
        check("async_valid", {31'd0, oValid}, 32'd0);
        check("async_pending", {24'd0, oPending}, 32'd0);
        check("async_opcode", {28'd0, oOpcode}, 32'd0);
        sb.delete();
        exp_pend = '0;
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock); #1;
        step(1'b1, 4'h8, 8'd1, 8'd2, 8'd7, 1'b1, 1'b0, 8'd0, 16'h0, 1'b1);
        idle(1'b0, 8'd0, 16'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
